// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared load-type codes, MEM/WB control struct and width check for wb_stage_pipe
package wb_pkg;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LD  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;
    localparam logic [2:0] LT_LWU = 3'b110;

    // Width-independent control half of the MEM/WB register.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_to_reg;
        logic [2:0] load_type;
    } wb_ctrl_t;

    // Only 32- and 64-bit datapaths are supported.
    function automatic bit data_w_legal(int w);
        return (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and sign/zero-extends a sub-word load from a raw memory word
module load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic [DATA_W-1:0] raw,
    input  logic [OFF_W-1:0]  off,
    input  logic [2:0]        load_type,
    output logic [DATA_W-1:0] data
);

    logic [OFF_W-1:0] off_h;
    logic [OFF_W-1:0] off_w;
    logic [7:0]       b;
    logic [15:0]      h;
    logic [31:0]      w;

    // Halfword and word accesses ignore the offset bits below their natural alignment.
    always_comb begin
        off_h      = off;
        off_h[0]   = 1'b0;
        off_w      = off;
        off_w[1:0] = 2'b00;
        b = 8'(raw >> {off, 3'b000});
        h = 16'(raw >> {off_h, 3'b000});
        w = 32'(raw >> {off_w, 3'b000});
    end

    // Extend the selected field; codes not valid for this width return zero.
    always_comb begin
        data = '0;
        case (load_type)
            LT_LB:   data = DATA_W'($signed(b));
            LT_LH:   data = DATA_W'($signed(h));
            LT_LW:   data = DATA_W'($signed(w));
            LT_LBU:  data = DATA_W'(b);
            LT_LHU:  data = DATA_W'(h);
            LT_LD:   data = (DATA_W == 64) ? raw : '0;
            LT_LWU:  data = (DATA_W == 64) ? DATA_W'(w) : '0;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// rtl/wb_stage_pipe.sv - registered write-back stage with retire counter; optional WB_BYPASS_EN bypass
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32,
    localparam int OFF_W = $clog2(DATA_W/8)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic              RegWrite_i,
    input  logic              MemToReg_i,
    input  logic [2:0]        LoadType_i,
    input  logic [OFF_W-1:0]  ByteOff_i,
    input  logic [DATA_W-1:0] ReadData_i,
    input  logic [DATA_W-1:0] ALUdata_i,
    input  logic [REG_AW-1:0] RegAddr_i,
`ifdef WB_BYPASS_EN
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    output logic [DATA_W-1:0] rs1_data_o,
    output logic [DATA_W-1:0] rs2_data_o,
`endif
    output logic              valid_o,
    output logic              RegWrite_o,
    output logic [REG_AW-1:0] RegAddr_o,
    output logic [DATA_W-1:0] RegData_o,
    output logic [CNT_W-1:0]  retire_cnt_o
);

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $error("wb_stage_pipe: DATA_W must be 32 or 64");
    end

    wb_ctrl_t          ctrl_q;
    logic [OFF_W-1:0]  byte_off_q;
    logic [DATA_W-1:0] read_data_q;
    logic [DATA_W-1:0] alu_q;
    logic [REG_AW-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] load_data;
    logic              retire;

    // MEM/WB register: reset clears everything, flush only kills the slot, stall holds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q      <= '0;
            byte_off_q  <= '0;
            read_data_q <= '0;
            alu_q       <= '0;
            addr_q      <= '0;
        end else if (flush_i) begin
            ctrl_q.valid <= 1'b0;
        end else if (!stall_i) begin
            ctrl_q.valid      <= valid_i;
            ctrl_q.reg_write  <= RegWrite_i;
            ctrl_q.mem_to_reg <= MemToReg_i;
            ctrl_q.load_type  <= LoadType_i;
            byte_off_q        <= ByteOff_i;
            read_data_q       <= ReadData_i;
            alu_q             <= ALUdata_i;
            addr_q            <= RegAddr_i;
        end
    end

    // A held instruction retires in the first cycle it is not stalled.
    assign retire = ctrl_q.valid & ~stall_i;

    // Retire counter wraps naturally at its width.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (retire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    load_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_load_align (
        .raw       (read_data_q),
        .off       (byte_off_q),
        .load_type (ctrl_q.load_type),
        .data      (load_data)
    );

    // Register-file write port; x0 is never written and a stalled slot never writes.
    always_comb begin
        valid_o      = ctrl_q.valid;
        RegWrite_o   = ctrl_q.valid & ctrl_q.reg_write & (addr_q != '0) & ~stall_i;
        RegAddr_o    = addr_q;
        RegData_o    = ctrl_q.mem_to_reg ? load_data : alu_q;
        retire_cnt_o = cnt_q;
    end

`ifdef WB_BYPASS_EN
    // Same-cycle forwarding of the value being written; RegWrite_o already excludes x0.
    always_comb begin
        rs1_data_o = rs1_data_i;
        rs2_data_o = rs2_data_i;
        if (RegWrite_o && (rs1_addr_i == RegAddr_o) && (rs1_addr_i != '0)) begin
            rs1_data_o = RegData_o;
        end
        if (RegWrite_o && (rs2_addr_i == RegAddr_o) && (rs2_addr_i != '0)) begin
            rs2_data_o = RegData_o;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb/tb_wb_stage_pipe.sv - directed self-checking bench for wb_stage_pipe
module tb_wb_stage_pipe;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;
    localparam int OFF_W  = 2;

    logic              clk = 1'b0;
    logic              rst, stall, flush, valid, rw, m2r;
    logic [2:0]        lt;
    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] rdata, alu;
    logic [REG_AW-1:0] addr;
    logic              valid_o, we_o;
    logic [REG_AW-1:0] addr_o;
    logic [DATA_W-1:0] data_o;
    logic [CNT_W-1:0]  cnt_o;
`ifdef WB_BYPASS_EN
    logic [REG_AW-1:0] rs1_a, rs2_a;
    logic [DATA_W-1:0] rs1_d, rs2_d, rs1_q, rs2_q;
`endif

    int total = 0;
    int bad   = 0;
    logic [CNT_W-1:0] exp_cnt;

    always #5 clk = ~clk;

    wb_stage_pipe #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .stall_i      (stall),
        .flush_i      (flush),
        .valid_i      (valid),
        .RegWrite_i   (rw),
        .MemToReg_i   (m2r),
        .LoadType_i   (lt),
        .ByteOff_i    (off),
        .ReadData_i   (rdata),
        .ALUdata_i    (alu),
        .RegAddr_i    (addr),
`ifdef WB_BYPASS_EN
        .rs1_addr_i   (rs1_a),
        .rs2_addr_i   (rs2_a),
        .rs1_data_i   (rs1_d),
        .rs2_data_i   (rs2_d),
        .rs1_data_o   (rs1_q),
        .rs2_data_o   (rs2_q),
`endif
        .valid_o      (valid_o),
        .RegWrite_o   (we_o),
        .RegAddr_o    (addr_o),
        .RegData_o    (data_o),
        .retire_cnt_o (cnt_o)
    );

    typedef struct {
        logic              v;
        logic              rw;
        logic              m2r;
        logic [2:0]        lt;
        logic [OFF_W-1:0]  off;
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] alu;
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] exp_data;
        logic              exp_we;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v_, input logic rw_, input logic m_, input logic [2:0] lt_,
                         input logic [OFF_W-1:0] off_, input logic [DATA_W-1:0] rd_,
                         input logic [DATA_W-1:0] alu_, input logic [REG_AW-1:0] a_);
        valid = v_; rw = rw_; m2r = m_; lt = lt_; off = off_; rdata = rd_; alu = alu_; addr = a_;
    endtask

    initial begin
        vecs[0]  = '{1, 1, 0, 3'b000, 2'd0, 32'h0,         32'h1234_5678, 5'd7,  32'h1234_5678, 1};
        vecs[1]  = '{1, 1, 1, 3'b000, 2'd3, 32'h80FF_7F01, 32'h0,         5'd1,  32'hFFFF_FF80, 1};
        vecs[2]  = '{1, 1, 1, 3'b100, 2'd3, 32'h80FF_7F01, 32'h0,         5'd2,  32'h0000_0080, 1};
        vecs[3]  = '{1, 1, 1, 3'b001, 2'd2, 32'h80FF_7F01, 32'h0,         5'd3,  32'hFFFF_80FF, 1};
        vecs[4]  = '{1, 1, 1, 3'b101, 2'd0, 32'h80FF_7F01, 32'h0,         5'd4,  32'h0000_7F01, 1};
        vecs[5]  = '{1, 1, 1, 3'b010, 2'd0, 32'h80FF_7F01, 32'h0,         5'd5,  32'h80FF_7F01, 1};
        vecs[6]  = '{1, 1, 1, 3'b010, 2'd2, 32'h80FF_7F01, 32'h0,         5'd6,  32'h80FF_7F01, 1};
        vecs[7]  = '{1, 1, 1, 3'b001, 2'd3, 32'h80FF_7F01, 32'h0,         5'd8,  32'hFFFF_80FF, 1};
        vecs[8]  = '{1, 1, 1, 3'b000, 2'd1, 32'h80FF_7F01, 32'h0,         5'd9,  32'h0000_007F, 1};
        vecs[9]  = '{1, 1, 1, 3'b011, 2'd0, 32'h80FF_7F01, 32'h0,         5'd10, 32'h0000_0000, 1};
        vecs[10] = '{1, 1, 0, 3'b000, 2'd0, 32'h0,         32'h0000_DEAD, 5'd0,  32'h0000_DEAD, 0};
        vecs[11] = '{1, 0, 0, 3'b000, 2'd0, 32'h0,         32'h0000_BEEF, 5'd4,  32'h0000_BEEF, 0};
        vecs[12] = '{0, 1, 0, 3'b000, 2'd0, 32'h0,         32'h0000_CAFE, 5'd6,  32'h0000_CAFE, 0};

        rst = 1; stall = 0; flush = 0;
        drive(0, 0, 0, 3'b000, '0, '0, '0, '0);
`ifdef WB_BYPASS_EN
        rs1_a = '0; rs2_a = '0; rs1_d = 32'h1111_1111; rs2_d = 32'h2222_2222;
`endif
        cyc(); cyc();
        rst = 0;
        chk("rst_valid", valid_o, 0);
        chk("rst_we",    we_o,    0);
        chk("rst_addr",  addr_o,  0);
        chk("rst_data",  data_o,  0);
        chk("rst_cnt",   cnt_o,   0);
        exp_cnt = '0;

        // table: each vector is visible for one cycle, then retires on the following edge
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].v, vecs[i].rw, vecs[i].m2r, vecs[i].lt, vecs[i].off,
                  vecs[i].rdata, vecs[i].alu, vecs[i].addr);
            cyc();
            chk($sformatf("v%0d_valid", i), valid_o, vecs[i].v);
            chk($sformatf("v%0d_we", i),    we_o,    vecs[i].exp_we);
            chk($sformatf("v%0d_addr", i),  addr_o,  vecs[i].addr);
            chk($sformatf("v%0d_data", i),  data_o,  vecs[i].exp_data);
            chk($sformatf("v%0d_cnt", i),   cnt_o,   exp_cnt);
            exp_cnt = exp_cnt + CNT_W'(vecs[i].v);
        end
        cyc();
        chk("after_table_cnt", cnt_o, exp_cnt);

        // stall 3 cycles on addr 5, next instruction waits at the inputs
        drive(1, 1, 0, 3'b000, '0, '0, 32'h0000_0055, 5'd5);
        cyc();
        drive(1, 1, 0, 3'b000, '0, '0, 32'h0000_0099, 5'd9);
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_we", k),   we_o,   0);
            chk($sformatf("stall%0d_addr", k), addr_o, 5);
            chk($sformatf("stall%0d_data", k), data_o, 32'h55);
            chk($sformatf("stall%0d_cnt", k),  cnt_o,  exp_cnt);
            cyc();
        end
        stall = 0;
        #1;
        chk("unstall_we",   we_o,   1);
        chk("unstall_addr", addr_o, 5);
        chk("unstall_cnt",  cnt_o,  exp_cnt);
        cyc();
        exp_cnt = exp_cnt + 1'b1;
        chk("after_stall_cnt",  cnt_o,  exp_cnt);
        chk("after_stall_addr", addr_o, 9);

        // flush and stall together: held addr 9 is discarded uncounted
        drive(1, 1, 0, 3'b000, '0, '0, 32'h0000_00AA, 5'd10);
        flush = 1; stall = 1;
        #1;
        chk("fs_we_during", we_o, 0);
        cyc();
        flush = 0; stall = 0;
        #1;
        chk("fs_valid", valid_o, 0);
        chk("fs_we",    we_o,    0);
        chk("fs_cnt",   cnt_o,   exp_cnt);
        cyc();
        chk("fs_reload_addr", addr_o, 10);
        chk("fs_bubble_cnt",  cnt_o,  exp_cnt);

        // flush alone: held addr 10 still retires
        flush = 1;
        cyc();
        flush = 0;
        exp_cnt = exp_cnt + 1'b1;
        chk("flush_valid", valid_o, 0);
        chk("flush_cnt",   cnt_o,   exp_cnt);

        // back-to-back valid instructions until the 4-bit counter wraps
        drive(1, 1, 0, 3'b000, '0, '0, 32'h0000_0033, 5'd3);
        cyc();
        chk("wrap_load_cnt", cnt_o, exp_cnt);
        for (int k = 0; k < 4; k++) begin
            cyc();
            exp_cnt = exp_cnt + 1'b1;
            chk($sformatf("wrap%0d_cnt", k), cnt_o, exp_cnt);
        end
        chk("wrap_zero_seen", exp_cnt, 4'd2);

`ifdef WB_BYPASS_EN
        drive(1, 1, 0, 3'b000, '0, '0, 32'hA5A5_A5A5, 5'd9);
        cyc();
        rs1_a = 5'd9; rs2_a = 5'd0;
        #1;
        chk("byp_rs1", rs1_q, 32'hA5A5_A5A5);
        chk("byp_rs2", rs2_q, 32'h2222_2222);
        stall = 1;
        #1;
        chk("byp_stall_rs1", rs1_q, 32'h1111_1111);
        stall = 0;
        rs1_a = 5'd8;
        #1;
        chk("byp_miss_rs1", rs1_q, 32'h1111_1111);
`endif

        // reset mid-stream: valid instruction in flight is dropped
        drive(1, 1, 0, 3'b000, '0, '0, 32'h0000_0077, 5'd12);
        cyc();
        chk("pre_rst_valid", valid_o, 1);
        rst = 1;
        cyc(); cyc();
        rst = 0;
        drive(0, 0, 0, 3'b000, '0, '0, '0, '0);
        #1;
        chk("midrst_valid", valid_o, 0);
        chk("midrst_we",    we_o,    0);
        chk("midrst_addr",  addr_o,  0);
        chk("midrst_data",  data_o,  0);
        chk("midrst_cnt",   cnt_o,   0);
        cyc();
        chk("post_rst_cnt", cnt_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
